// File: rtl/fp_issue_scheduler.sv
// fp_issue_scheduler
// Issue scheduler and writeback sequencer for the RV32F OP-FP datapath.
// Tracks FP-register RAW/WAW hazards with a 32-entry scoreboard, dispatches
// to the add/mul pipe, the iterative div/sqrt unit or the one-cycle misc unit,
// and drives the single register-file writeback port.
// Optional feature: define FP_SCHED_WB_BYPASS_EN to let the hazard check see
// registers being cleared by the same cycle's writeback.
module fp_issue_scheduler #(
    parameter int PIPE_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_funct7,
    input  logic [2:0] cmd_funct3,
    input  logic [4:0] cmd_rs1,
    input  logic [4:0] cmd_rs2,
    input  logic [4:0] cmd_rd,
    output logic       cmd_illegal,
    output logic [6:0] issue_funct7,
    output logic [2:0] issue_funct3,
    output logic [4:0] issue_rs1,
    output logic [4:0] issue_rs2,
    output logic [4:0] issue_rd,
    output logic       pipe_start,
    output logic       misc_start,
    output logic       iter_start,
    input  logic       iter_done,
    output logic       iter_ack,
    output logic       wb_valid,
    output logic [1:0] wb_sel,
    output logic [4:0] wb_rd,
    output logic       wb_int
);

    localparam logic [6:0] F7_FADD     = 7'b0000000;
    localparam logic [6:0] F7_FSUB     = 7'b0000100;
    localparam logic [6:0] F7_FMUL     = 7'b0001000;
    localparam logic [6:0] F7_FDIV     = 7'b0001100;
    localparam logic [6:0] F7_FSQRT    = 7'b0101100;
    localparam logic [6:0] F7_FSGNJ    = 7'b0010000;
    localparam logic [6:0] F7_FMINMAX  = 7'b0010100;
    localparam logic [6:0] F7_FCVT_W_S = 7'b1100000;
    localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;
    localparam logic [6:0] F7_FCMP     = 7'b1010000;
    localparam logic [6:0] F7_FCVT_S_W = 7'b1101000;
    localparam logic [6:0] F7_FMV_W_X  = 7'b1111000;

    localparam logic [1:0] SEL_PIPE = 2'd0;
    localparam logic [1:0] SEL_MISC = 2'd1;
    localparam logic [1:0] SEL_ITER = 2'd2;

    // One reserved writeback slot; position 0 of the shift register is "now".
    typedef struct packed {
        logic       v;
        logic       misc;
        logic       is_int;
        logic [4:0] rd;
    } res_t;

    logic [31:0] r_busy;
    res_t        r_res [0:PIPE_LATENCY];
    logic        r_iter_busy;
    logic [4:0]  r_iter_rd;

    logic [6:0]  r_issue_funct7;
    logic [2:0]  r_issue_funct3;
    logic [4:0]  r_issue_rs1;
    logic [4:0]  r_issue_rs2;
    logic [4:0]  r_issue_rd;
    logic        r_pipe_start;
    logic        r_misc_start;
    logic        r_iter_start;
    logic        r_illegal;

    logic        w_is_pipe;
    logic        w_is_misc;
    logic        w_is_iter;
    logic        w_rd_int;
    logic        w_chk_rs1;
    logic        w_chk_rs2;
    logic        w_legal;
    logic        w_fp_dest;
    logic        w_unit_ok;
    logic        w_hazard;
    logic        w_ready;
    logic        w_hs;
    logic [31:0] w_busy_eff;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    res_t        w_entry;

    logic        w_iter_ack;
    logic        w_wb_valid;
    logic [1:0]  w_wb_sel;
    logic [4:0]  w_wb_rd;
    logic        w_wb_int;

    // Class decode of the incoming funct7: target unit, dest file, sources to check.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_is_pipe = 1'b0;
        w_is_misc = 1'b0;
        w_is_iter = 1'b0;
        w_rd_int  = 1'b0;
        w_chk_rs1 = 1'b0;
        w_chk_rs2 = 1'b0;
        case (cmd_funct7)
            F7_FADD, F7_FSUB, F7_FMUL: begin
                w_is_pipe = 1'b1;
                w_chk_rs1 = 1'b1;
                w_chk_rs2 = 1'b1;
            end
            F7_FDIV: begin
                w_is_iter = 1'b1;
                w_chk_rs1 = 1'b1;
                w_chk_rs2 = 1'b1;
            end
            F7_FSQRT: begin
                w_is_iter = 1'b1;
                w_chk_rs1 = 1'b1;
            end
            F7_FSGNJ, F7_FMINMAX: begin
                w_is_misc = 1'b1;
                w_chk_rs1 = 1'b1;
                w_chk_rs2 = 1'b1;
            end
            F7_FCMP: begin
                w_is_misc = 1'b1;
                w_rd_int  = 1'b1;
                w_chk_rs1 = 1'b1;
                w_chk_rs2 = 1'b1;
            end
            F7_FCVT_W_S, F7_FMV_X_W: begin
                w_is_misc = 1'b1;
                w_rd_int  = 1'b1;
                w_chk_rs1 = 1'b1;
            end
            F7_FCVT_S_W, F7_FMV_W_X: begin
                w_is_misc = 1'b1;
            end
            default: ;
        endcase
    end

    // Writeback port: a reserved pipe/misc slot always wins over the iterative unit.
    always_comb begin
        w_iter_ack = !rst && iter_done && !r_res[0].v;
        w_wb_valid = 1'b0;
        w_wb_sel   = SEL_PIPE;
        w_wb_rd    = 5'd0;
        w_wb_int   = 1'b0;
        if (r_res[0].v) begin
            w_wb_valid = 1'b1;
            w_wb_sel   = r_res[0].misc ? SEL_MISC : SEL_PIPE;
            w_wb_rd    = r_res[0].rd;
            w_wb_int   = r_res[0].is_int;
        end else if (w_iter_ack && r_iter_busy) begin
            // An ack with no iterative op outstanding drains a result from before reset.
            w_wb_valid = 1'b1;
            w_wb_sel   = SEL_ITER;
            w_wb_rd    = r_iter_rd;
        end
    end

    assign w_legal    = w_is_pipe || w_is_misc || w_is_iter;
    assign w_fp_dest  = w_legal && !w_rd_int;
    assign w_clr_mask = (w_wb_valid && !w_wb_int) ? (32'd1 << w_wb_rd) : 32'd0;

`ifdef FP_SCHED_WB_BYPASS_EN
    // The datapath forwards the writeback value, so a register freed this cycle is usable.
    assign w_busy_eff = r_busy & ~w_clr_mask;
`else
    assign w_busy_eff = r_busy;
`endif

    assign w_hazard  = (w_chk_rs1 && w_busy_eff[cmd_rs1]) ||
                       (w_chk_rs2 && w_busy_eff[cmd_rs2]) ||
                       (w_fp_dest && w_busy_eff[cmd_rd]);
    // A misc op would land in slot 1 next cycle, which is where a pipe entry in slot 2 moves.
    assign w_unit_ok = w_is_misc ? !r_res[2].v :
                       w_is_iter ? !r_iter_busy : 1'b1;
    assign w_ready   = !rst && !w_hazard && w_unit_ok;
    assign w_hs      = cmd_valid && w_ready;

    assign w_set_mask = (w_hs && w_fp_dest) ? (32'd1 << cmd_rd) : 32'd0;
    assign w_entry    = '{v: 1'b1, misc: w_is_misc, is_int: w_rd_int, rd: cmd_rd};

    // Scoreboard: a set and a clear of the same register in one cycle leaves it busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
        end
    end

    // Writeback reservation shift register, advancing one slot per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this array is a small reservation pipeline whose valid bits gate writebacks, so it is reset like any other control flop.
            for (int i = 0; i <= PIPE_LATENCY; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                r_res[i] <= r_res[i+1];
            end
            r_res[PIPE_LATENCY] <= '0;
            if (w_hs && w_is_pipe) begin
                r_res[PIPE_LATENCY] <= w_entry;
            end
            if (w_hs && w_is_misc) begin
                r_res[1] <= w_entry;
            end
        end
    end

    // Single in-flight iterative op: busy from handshake until its result is acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iter_busy <= 1'b0;
            r_iter_rd   <= 5'd0;
        end else if (w_hs && w_is_iter) begin
            r_iter_busy <= 1'b1;
            r_iter_rd   <= cmd_rd;
        end else if (w_iter_ack) begin
            r_iter_busy <= 1'b0;
        end
    end

    // Registered op broadcast and one-cycle start / illegal pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_funct7 <= 7'd0;
            r_issue_funct3 <= 3'd0;
            r_issue_rs1    <= 5'd0;
            r_issue_rs2    <= 5'd0;
            r_issue_rd     <= 5'd0;
            r_pipe_start   <= 1'b0;
            r_misc_start   <= 1'b0;
            r_iter_start   <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_pipe_start <= w_hs && w_is_pipe;
            r_misc_start <= w_hs && w_is_misc;
            r_iter_start <= w_hs && w_is_iter;
            r_illegal    <= w_hs && !w_legal;
            if (w_hs && w_legal) begin
                r_issue_funct7 <= cmd_funct7;
                r_issue_funct3 <= cmd_funct3;
                r_issue_rs1    <= cmd_rs1;
                r_issue_rs2    <= cmd_rs2;
                r_issue_rd     <= cmd_rd;
            end
        end
    end

    assign cmd_ready    = w_ready;
    assign cmd_illegal  = r_illegal;
    assign issue_funct7 = r_issue_funct7;
    assign issue_funct3 = r_issue_funct3;
    assign issue_rs1    = r_issue_rs1;
    assign issue_rs2    = r_issue_rs2;
    assign issue_rd     = r_issue_rd;
    assign pipe_start   = r_pipe_start;
    assign misc_start   = r_misc_start;
    assign iter_start   = r_iter_start;
    assign iter_ack     = w_iter_ack;
    assign wb_valid     = w_wb_valid;
    assign wb_sel       = w_wb_sel;
    assign wb_rd        = w_wb_rd;
    assign wb_int       = w_wb_int;

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// tb_fp_issue_scheduler
// Directed and randomized stimulus against a transaction-level model: each
// accepted instruction becomes a pending writeback with an absolute due cycle,
// register busy-ness is derived from the pending list, and the iterative unit
// is modelled by the bench with a random result delay.
module tb_fp_issue_scheduler;

    localparam int LAT = 4;
`ifdef FP_SCHED_WB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    localparam logic [6:0] FADD = 7'b0000000, FSUB = 7'b0000100, FMUL = 7'b0001000;
    localparam logic [6:0] FDIV = 7'b0001100, FSQRT = 7'b0101100, FSGNJ = 7'b0010000;
    localparam logic [6:0] FMINMAX = 7'b0010100, FCVTWS = 7'b1100000, FMVXW = 7'b1110000;
    localparam logic [6:0] FCMP = 7'b1010000, FCVTSW = 7'b1101000, FMVWX = 7'b1111000;
    localparam logic [6:0] ILL = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_funct7;
    logic [2:0] cmd_funct3;
    logic [4:0] cmd_rs1, cmd_rs2, cmd_rd;
    logic       cmd_illegal;
    logic [6:0] issue_funct7;
    logic [2:0] issue_funct3;
    logic [4:0] issue_rs1, issue_rs2, issue_rd;
    logic       pipe_start, misc_start, iter_start;
    logic       iter_done, iter_ack;
    logic       wb_valid;
    logic [1:0] wb_sel;
    logic [4:0] wb_rd;
    logic       wb_int;

    always #5 clk = ~clk;

    fp_issue_scheduler #(.PIPE_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_funct7(cmd_funct7), .cmd_funct3(cmd_funct3),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
        .cmd_illegal(cmd_illegal),
        .issue_funct7(issue_funct7), .issue_funct3(issue_funct3),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .pipe_start(pipe_start), .misc_start(misc_start), .iter_start(iter_start),
        .iter_done(iter_done), .iter_ack(iter_ack),
        .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_rd(wb_rd), .wb_int(wb_int)
    );

    // A pending writeback: sel 0 pipe, 1 misc, 2 iter; wb_cyc -1 means not yet known.
    typedef struct {
        int rd;
        int sel;
        bit is_int;
        int wb_cyc;
    } pend_t;

    pend_t pend[$];
    int    now;
    int    checks;
    int    errors;
    int    last_acc_cyc;
    int    iter_cnt;
    int    forced_delay;
    bit    unit_done;
    bit    e_pipe_start, e_misc_start, e_iter_start, e_illegal;
    logic [6:0] e_f7;
    logic [2:0] e_f3;
    logic [4:0] e_rs1, e_rs2, e_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, now);
        end
    endtask

    // Instruction class table: cls 0 pipe, 1 misc, 2 iter, 3 unknown.
    task automatic classify(input logic [6:0] f7, output int cls, output bit is_int,
                            output bit c1, output bit c2);
        cls = 3; is_int = 0; c1 = 0; c2 = 0;
        case (f7)
            FADD, FSUB, FMUL:   begin cls = 0; c1 = 1; c2 = 1; end
            FDIV:               begin cls = 2; c1 = 1; c2 = 1; end
            FSQRT:              begin cls = 2; c1 = 1; end
            FSGNJ, FMINMAX:     begin cls = 1; c1 = 1; c2 = 1; end
            FCMP:               begin cls = 1; c1 = 1; c2 = 1; is_int = 1; end
            FCVTWS, FMVXW:      begin cls = 1; c1 = 1; is_int = 1; end
            FCVTSW, FMVWX:      begin cls = 1; end
            default: ;
        endcase
    endtask

    // A register is busy while its producer has not written back before this cycle
    // (or, with forwarding, by the end of this cycle).
    function automatic bit reg_busy(input int r);
        foreach (pend[i])
            if (!pend[i].is_int && pend[i].rd == r &&
                (pend[i].wb_cyc < 0 || pend[i].wb_cyc >= now + BYP))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit slot_taken(input int c);
        foreach (pend[i])
            if (pend[i].wb_cyc == c) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive at the falling edge, check 1 ns later, update the model.
    task automatic step(input bit v, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        output bit acc);
        int cls, exp_sel, exp_rd;
        bit is_int, c1, c2, ack, exp_ready, exp_wb, exp_int, iter_out, iter_new;
        if (iter_cnt == 0) begin
            unit_done = 1'b1;
            iter_cnt  = -1;
        end
        cmd_valid = v; cmd_funct7 = f7; cmd_funct3 = f3;
        cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
        iter_done = unit_done;
        #1;
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].wb_cyc >= 0 && pend[i].wb_cyc < now) pend.delete(i);
        exp_wb = 0; exp_sel = 0; exp_rd = 0; exp_int = 0;
        foreach (pend[i])
            if (pend[i].wb_cyc == now) begin
                exp_wb = 1; exp_sel = pend[i].sel; exp_rd = pend[i].rd; exp_int = pend[i].is_int;
            end
        ack = unit_done && !exp_wb;
        iter_out = 0;
        foreach (pend[i])
            if (pend[i].sel == 2) begin
                iter_out = 1;
                if (ack && pend[i].wb_cyc < 0) begin
                    pend[i].wb_cyc = now;
                    exp_wb = 1; exp_sel = 2; exp_rd = pend[i].rd; exp_int = 0;
                end
            end
        classify(f7, cls, is_int, c1, c2);
        exp_ready = 1;
        if (c1 && reg_busy(rs1)) exp_ready = 0;
        if (c2 && reg_busy(rs2)) exp_ready = 0;
        if (cls != 3 && !is_int && reg_busy(rd)) exp_ready = 0;
        if (cls == 1 && slot_taken(now + 2)) exp_ready = 0;
        if (cls == 2 && iter_out) exp_ready = 0;

        check("cmd_ready", cmd_ready, exp_ready);
        check("wb_valid", wb_valid, exp_wb);
        if (exp_wb) begin
            check("wb_sel", wb_sel, exp_sel);
            check("wb_rd", wb_rd, exp_rd);
            check("wb_int", wb_int, exp_int);
        end
        check("iter_ack", iter_ack, ack);
        check("pipe_start", pipe_start, e_pipe_start);
        check("misc_start", misc_start, e_misc_start);
        check("iter_start", iter_start, e_iter_start);
        check("cmd_illegal", cmd_illegal, e_illegal);
        if (e_pipe_start || e_misc_start || e_iter_start) begin
            check("issue_funct7", issue_funct7, e_f7);
            check("issue_funct3", issue_funct3, e_f3);
            check("issue_rs1", issue_rs1, e_rs1);
            check("issue_rs2", issue_rs2, e_rs2);
            check("issue_rd", issue_rd, e_rd);
        end

        e_pipe_start = 0; e_misc_start = 0; e_iter_start = 0; e_illegal = 0;
        iter_new = 0;
        acc = v && exp_ready;
        if (acc) begin
            last_acc_cyc = now;
            if (cls == 3) begin
                e_illegal = 1;
            end else begin
                e_f7 = f7; e_f3 = f3; e_rs1 = rs1; e_rs2 = rs2; e_rd = rd;
                if (cls == 0) begin
                    e_pipe_start = 1;
                    pend.push_back('{int'(rd), 0, 1'b0, now + 1 + LAT});
                end else if (cls == 1) begin
                    e_misc_start = 1;
                    pend.push_back('{int'(rd), 1, is_int, now + 2});
                end else begin
                    e_iter_start = 1;
                    pend.push_back('{int'(rd), 2, 1'b0, -1});
                    iter_cnt = 1 + ((forced_delay >= 0) ? forced_delay : int'($urandom_range(1, 5)));
                    forced_delay = -1;
                    iter_new = 1;
                end
            end
        end
        if (ack) unit_done = 1'b0;
        if (!iter_new && iter_cnt > 0) iter_cnt--;
        @(negedge clk);
        now++;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, FADD, 3'd0, 5'd0, 5'd0, 5'd0, acc);
    endtask

    // Retry one instruction until accepted, bounded by a cycle budget.
    task automatic issue_until(input string tag, input logic [6:0] f7, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd, output int acc_cyc);
        bit acc = 0;
        for (int k = 0; k < 40 && !acc; k++) step(1'b1, f7, 3'd1, rs1, rs2, rd, acc);
        check({tag, "_accepted"}, acc, 1);
        acc_cyc = last_acc_cyc;
    endtask

    // Assert reset mid-flight; optionally leave a stale iter_done high across it.
    task automatic do_reset(input bit stale_done);
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_funct7 = FADD; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_rd = 5'd0;
        unit_done = stale_done;
        iter_done = stale_done;
        iter_cnt = -1;
        #1;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_sel", wb_sel, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_int", wb_int, 0);
        check("rst_iter_ack", iter_ack, 0);
        check("rst_pipe_start", pipe_start, 0);
        check("rst_misc_start", misc_start, 0);
        check("rst_iter_start", iter_start, 0);
        check("rst_illegal", cmd_illegal, 0);
        check("rst_issue_funct7", issue_funct7, 0);
        check("rst_issue_rd", issue_rd, 0);
        pend.delete();
        e_pipe_start = 0; e_misc_start = 0; e_iter_start = 0; e_illegal = 0;
        e_f7 = '0; e_f3 = '0; e_rs1 = '0; e_rs2 = '0; e_rd = '0;
        @(negedge clk);
        now++;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t0, ta;
        bit  acc;
        logic [6:0] ops [13];
        ops = '{FADD, FSUB, FMUL, FDIV, FSQRT, FSGNJ, FMINMAX,
                FCVTWS, FMVXW, FCMP, FCVTSW, FMVWX, ILL};
        checks = 0; errors = 0; now = 0; iter_cnt = -1; forced_delay = -1; unit_done = 0;
        rst = 1'b1; cmd_valid = 0; cmd_funct7 = '0; cmd_funct3 = '0;
        cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; iter_done = 0;
        @(negedge clk);
        do_reset(1'b0);

        // FADD f1,f2,f3: start next cycle, FP writeback of f1 after PIPE_LATENCY more.
        step(1'b1, FADD, 3'd0, 5'd2, 5'd3, 5'd1, acc);
        check("fadd_accepted", acc, 1);
        idle(8);

        // FMUL f4 then dependent FSGNJ f5,f4,f4: held off until f4's writeback.
        step(1'b1, FMUL, 3'd0, 5'd2, 5'd3, 5'd4, acc);
        t0 = last_acc_cyc;
        issue_until("fsgnj", FSGNJ, 5'd4, 5'd4, 5'd5, ta);
        check("raw_stall_cycles", ta - t0, 6 - BYP);
        idle(8);

        // FADD then FMIN_MAX three cycles later: misc slot collides, one-cycle stall.
        step(1'b1, FADD, 3'd0, 5'd9, 5'd10, 5'd8, acc);
        t0 = last_acc_cyc;
        idle(2);
        issue_until("fminmax", FMINMAX, 5'd12, 5'd13, 5'd11, ta);
        check("misc_slot_stall", ta - t0, 4);
        idle(8);

        // FDIV f6 with its result landing on a pipe writeback cycle, then FSQRT f7.
        forced_delay = 4;
        step(1'b1, FDIV, 3'd0, 5'd21, 5'd22, 5'd6, acc);
        t0 = last_acc_cyc;
        step(1'b1, FADD, 3'd0, 5'd15, 5'd16, 5'd14, acc);
        issue_until("fsqrt", FSQRT, 5'd20, 5'd0, 5'd7, ta);
        check("iter_serialise", ta - t0, 8);
        idle(12);

        // Integer-destination compare, then an unknown funct7.
        step(1'b1, FCMP, 3'd2, 5'd1, 5'd2, 5'd3, acc);
        idle(3);
        step(1'b1, ILL, 3'd0, 5'd1, 5'd2, 5'd3, acc);
        check("illegal_accepted", acc, 1);
        idle(3);

        // Reset with three pipe ops in flight and a stale iterative result pending.
        step(1'b1, FADD, 3'd0, 5'd0, 5'd0, 5'd17, acc);
        step(1'b1, FMUL, 3'd0, 5'd0, 5'd0, 5'd18, acc);
        step(1'b1, FSUB, 3'd0, 5'd0, 5'd0, 5'd19, acc);
        do_reset(1'b1);
        step(1'b1, FADD, 3'd0, 5'd1, 5'd2, 5'd17, acc);
        check("post_rst_accept", acc, 1);
        idle(8);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset(unit_done);
            end else begin
                step($urandom_range(0, 9) < 7, ops[$urandom_range(0, 12)], 3'($urandom),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), acc);
            end
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
